lsu_sram_ctrl: RTL and testbench

// - Load/store controller between the core's memory stage and the SRAM DPI model.
// - Accepts one request at a time on a valid/ready handshake.
// - Builds the word address, byte strobe and lane-replicated write data.
// - Absorbs the SRAM's 1-cycle registered read latency, then aligns and sign/zero-extends load data.
// - Returns each result on a valid/ready response channel.

---
 rtl/lsu_sram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_sram_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sram_ctrl.sv
// Load/store controller between the core memory stage and a 1-cycle-latency SRAM.
// Optional misaligned-access trap: define LSU_MISALIGN_CHECK_EN.
module lsu_sram_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [XLEN-1:0]   req_pc_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              sram_valid_o,
  output logic              sram_write_o,
  output logic              sram_ifetch_o,
  output logic [XLEN-1:0]   sram_pc_o,
  output logic [XLEN-1:0]   sram_addr_o,
  output logic [XLEN/8-1:0] sram_strobe_o,
  output logic [XLEN-1:0]   sram_wdata_o,
  input  logic [XLEN-1:0]   sram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-3:0]   addr_q, addr_d;
  logic [XLEN/8-1:0] strobe_q, strobe_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]        req_off;
  logic [XLEN/8-1:0] req_strobe;
  logic [XLEN-1:0]   req_wdata_rep;
  logic              req_misalign;
  logic [XLEN-1:0]   rd_shift;
  logic [XLEN-1:0]   rd_fmt;

  // Byte offset actually used: low address bits a size cannot express are dropped.
  always_comb begin
    req_off       = 2'b00;
    req_strobe    = 4'b1111;
    req_wdata_rep = req_wdata_i;
    unique case (req_size_i)
      2'd0: begin
        req_off       = req_addr_i[1:0];
        req_strobe    = 4'b0001 << req_off;
        req_wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_off       = {req_addr_i[1], 1'b0};
        req_strobe    = 4'b0011 << req_off;
        req_wdata_rep = {2{req_wdata_i[15:0]}};
      end
      default: begin
        req_off       = 2'b00;
        req_strobe    = 4'b1111;
        req_wdata_rep = req_wdata_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misalign = (req_size_i == 2'd1) ? req_addr_i[0]
                      : (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  // Load alignment and sign/zero extension of the SRAM read word.
  assign rd_shift = sram_rdata_i >> {off_q, 3'b000};
  always_comb begin
    rd_fmt = rd_shift;
    unique case (size_q)
      2'd0:    rd_fmt = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_fmt = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_fmt = rd_shift;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d  = req_write_i;
          size_d   = req_size_i;
          uns_d    = req_unsigned_i;
          off_d    = req_off;
          addr_d   = req_addr_i[XLEN-1:2];
          strobe_d = req_strobe;
          wdata_d  = req_wdata_rep;
          pc_d     = req_pc_i;
          rdata_d  = '0;
          err_d    = req_misalign;
          state_d  = req_misalign ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = write_q ? RESP : DATA;
      DATA: begin
        rdata_d = rd_fmt;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      off_q    <= 2'd0;
      addr_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Handshake and strobe decode straight from state so async reset drops them at once.
  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign sram_valid_o  = (state_q == ISSUE);
  assign sram_write_o  = write_q;
  assign sram_ifetch_o = 1'b0;
  assign sram_pc_o     = pc_q;
  assign sram_addr_o   = {addr_q, 2'b00};
  assign sram_strobe_o = strobe_q;
  assign sram_wdata_o  = wdata_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Bench for lsu_sram_ctrl: byte-level memory model, per-cycle compare, directed vectors.
module tb_lsu_sram_ctrl;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_valid;
  logic        sram_write;
  logic        sram_ifetch;
  logic [31:0] sram_pc;
  logic [31:0] sram_addr;
  logic [3:0]  sram_strobe;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  int vecs = 0;
  int miss = 0;

  lsu_sram_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_pc_i(req_pc),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .sram_valid_o(sram_valid), .sram_write_o(sram_write), .sram_ifetch_o(sram_ifetch),
    .sram_pc_o(sram_pc), .sram_addr_o(sram_addr), .sram_strobe_o(sram_strobe),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM: word array, writes on strobed lanes, registered read data.
  logic [31:0] sram_mem [logic [29:0]];
  always @(posedge clk) begin
    if (sram_valid) begin
      if (sram_write) begin
        logic [31:0] w;
        w = sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : 32'h0;
        for (int i = 0; i < 4; i++) if (sram_strobe[i]) w[8*i +: 8] = sram_wdata[8*i +: 8];
        sram_mem[sram_addr[31:2]] = w;
      end else begin
        sram_rdata <= sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : 32'h0;
      end
    end
  end

  // Reference byte-addressed memory and access rules.
  logic [7:0] ref_mem [logic [31:0]];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] eff_addr(input logic [1:0] sz, input logic [31:0] a);
    return a & ~32'(nbytes(sz) - 1);
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return MisEn && ((a % 32'(nbytes(sz))) != 32'd0);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s;
    int lo;
    lo = int'(eff_addr(sz, a) % 32'd4);
    for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i < lo + nbytes(sz));
    return s;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ea;
    int nb;
    nb = nbytes(sz);
    ea = eff_addr(sz, a);
    v  = '0;
    for (int j = 0; j < nb; j++)
      v[8*j +: 8] = ref_mem.exists(ea + 32'(j)) ? ref_mem[ea + 32'(j)] : 8'h00;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    return v;
  endfunction

  // Per-cycle compare against the latency rules: access at n+1, response at n+1/n+2/n+3.
  bit          busy = 1'b0;
  bit          m_w, m_uns, m_err, m_done;
  logic [1:0]  m_sz;
  logic [31:0] m_a, m_wd, m_pc, m_rd;
  int          k;

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_sram_valid", 32'(sram_valid), 32'd0);
    end else begin
      check("ifetch", 32'(sram_ifetch), 32'd0);
      if (!busy) begin
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_sram_valid", 32'(sram_valid), 32'd0);
        if (req_valid) begin
          busy = 1'b1; k = 0; m_done = 1'b0;
          m_w = req_write; m_sz = req_size; m_uns = req_unsigned;
          m_a = req_addr; m_wd = req_wdata; m_pc = req_pc;
          m_err = misaligned(req_size, req_addr);
          m_rd = (m_w || m_err) ? 32'h0 : exp_load(m_sz, m_uns, m_a);
        end
      end else begin
        bit in_rsp, exp_sv;
        k++;
        in_rsp = m_err ? (k >= 1) : m_w ? (k >= 2) : (k >= 3);
        exp_sv = !m_err && (k == 1);
        check("busy_req_ready", 32'(req_ready), 32'd0);
        check("rsp_valid", 32'(rsp_valid), 32'(in_rsp));
        check("sram_valid", 32'(sram_valid), 32'(exp_sv));
        if (exp_sv) begin
          check("sram_write", 32'(sram_write), 32'(m_w));
          check("sram_addr", sram_addr, m_a & ~32'd3);
          check("sram_pc", sram_pc, m_pc);
          if (m_w) begin
            check("sram_strobe", 32'(sram_strobe), 32'(exp_strb(m_sz, m_a)));
            check("sram_wdata", sram_wdata, exp_wd(m_sz, m_wd));
          end
        end
        if (in_rsp) begin
          check("rsp_rdata", rsp_rdata, m_rd);
          check("rsp_err", 32'(rsp_err), 32'(m_err));
          if (m_w && !m_err && !m_done) begin
            for (int j = 0; j < nbytes(m_sz); j++)
              ref_mem[eff_addr(m_sz, m_a) + 32'(j)] = m_wd[8*j +: 8];
            m_done = 1'b1;
          end
          if (rsp_ready) busy = 1'b0;
        end
      end
    end
  end

  // One transaction; optional literal expectations pin the model.
  task automatic txn(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input bit chk,
                     input logic [31:0] l_rd, input bit l_err, input logic [3:0] l_strb,
                     input logic [31:0] l_wd, input logic [31:0] l_addr, input int l_lat);
    bit got, done, saw_sv;
    int lat, nrsp;
    logic [3:0]  o_strb;
    logic [31:0] o_wd, o_addr;
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a;
    req_wdata = wd; req_pc = a ^ 32'h0000_1000; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    done = 1'b0; saw_sv = 1'b0; lat = -1; nrsp = 0;
    o_strb = '0; o_wd = '0; o_addr = '0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (sram_valid) begin
        saw_sv = 1'b1; o_strb = sram_strobe; o_wd = sram_wdata; o_addr = sram_addr;
      end
      if (rsp_valid) begin
        if (lat < 0) lat = i;
        nrsp++;
        if (rsp_ready) begin
          done = 1'b1;
          if (chk) begin
            check("lit_rdata", rsp_rdata, l_rd);
            check("lit_err", 32'(rsp_err), 32'(l_err));
            check("lit_latency", 32'(lat), 32'(l_lat));
            check("lit_sram_access", 32'(saw_sv), 32'(!l_err));
            if (w && !l_err) begin
              check("lit_strobe", 32'(o_strb), 32'(l_strb));
              check("lit_wdata", o_wd, l_wd);
              check("lit_addr", o_addr, l_addr);
            end
          end
        end else if (nrsp == hold) begin
          @(posedge clk); #1 rsp_ready = 1'b1;
        end
      end
    end
    if (!done) check("response_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    @(negedge clk);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_sram_write", 32'(sram_write), 32'd0);
    check("rst_sram_addr", sram_addr, 32'h0);
    check("rst_sram_strobe", 32'(sram_strobe), 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'h0);
    check("rst_sram_pc", sram_pc, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Stores with literal strobe/data/address and n+2 latency.
    txn(1, 2'd2, 0, 32'h8000_0004, 32'hDEAD_BEEF, 0, 1, 32'h0, 0, 4'hF, 32'hDEAD_BEEF, 32'h8000_0004, 2);
    txn(1, 2'd0, 0, 32'h8000_0003, 32'h0000_00A5, 0, 1, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h8000_0000, 2);
    txn(1, 2'd2, 0, 32'h8000_0000, 32'h8001_F0FF, 0, 1, 32'h0, 0, 4'hF, 32'h8001_F0FF, 32'h8000_0000, 2);

    // Loads from 0x8001F0FF, n+3 latency.
    txn(0, 2'd0, 0, 32'h8000_0003, 32'h0, 0, 1, 32'hFFFF_FF80, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd0, 1, 32'h8000_0000, 32'h0, 0, 1, 32'h0000_00FF, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd1, 0, 32'h8000_0002, 32'h0, 0, 1, 32'hFFFF_8001, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd1, 1, 32'h8000_0002, 32'h0, 0, 1, 32'h0000_8001, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd2, 0, 32'h8000_0000, 32'h0, 0, 1, 32'h8001_F0FF, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd0, 0, 32'h8000_0001, 32'h0, 0, 1, 32'hFFFF_FFF0, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd1, 0, 32'h8000_0000, 32'h0, 0, 1, 32'hFFFF_F0FF, 0, 4'h0, 32'h0, 32'h0, 3);

    // Half store into upper lanes, size-3 word store and readbacks.
    txn(1, 2'd1, 0, 32'h8000_0006, 32'h0000_1234, 0, 1, 32'h0, 0, 4'b1100, 32'h1234_1234, 32'h8000_0004, 2);
    txn(0, 2'd1, 1, 32'h8000_0006, 32'h0, 0, 1, 32'h0000_1234, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd1, 0, 32'h8000_0004, 32'h0, 0, 1, 32'hFFFF_BEEF, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(1, 2'd3, 0, 32'h8000_0008, 32'hCAFE_F00D, 0, 1, 32'h0, 0, 4'hF, 32'hCAFE_F00D, 32'h8000_0008, 2);
    txn(0, 2'd3, 0, 32'h8000_0008, 32'h0, 0, 1, 32'hCAFE_F00D, 0, 4'h0, 32'h0, 32'h0, 3);

    // Back-pressure: response held 5 cycles.
    txn(0, 2'd0, 0, 32'h8000_0003, 32'h0, 5, 1, 32'hFFFF_FF80, 0, 4'h0, 32'h0, 32'h0, 3);

    // Reset during the ISSUE cycle of a store: write must not happen.
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000_0000;
    req_wdata = 32'h1122_3344; req_pc = 32'h8000_1000; req_valid = 1'b1; rsp_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = sram_valid;
    end
    check("rst_issue_reached", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_issue_sram_valid", 32'(sram_valid), 32'd0);
    check("rst_issue_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_issue_mem", sram_mem.exists(30'h2000_0000) ? sram_mem[30'h2000_0000] : 32'h0, 32'h8001_F0FF);
    @(posedge clk); #1 rst = 1'b0;
    txn(0, 2'd2, 0, 32'h8000_0000, 32'h0, 0, 1, 32'h8001_F0FF, 0, 4'h0, 32'h0, 32'h0, 3);

    // Misaligned accesses: trapped or silently aligned, depending on build.
    if (MisEn)
      txn(0, 2'd2, 0, 32'h8000_0002, 32'h0, 0, 1, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1);
    else
      txn(0, 2'd2, 0, 32'h8000_0002, 32'h0, 0, 1, 32'h8001_F0FF, 0, 4'h0, 32'h0, 32'h0, 3);
    txn(0, 2'd1, 0, 32'h8000_0001, 32'h0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    txn(1, 2'd1, 0, 32'h8000_0005, 32'h0000_7777, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    txn(0, 2'd2, 0, 32'h8000_0004, 32'h0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
